dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: n, 32, data and address width in bits.
REQ-002 Parameter: r, 7, implemented address bits; valid addresses satisfy addr[n-1:r]==0.
REQ-003 Clocking and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock shared with dmem.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 req0, req1  input  1  transaction request from port 0 (CPU) and port 1 (aux/debug).
REQ-007 we0, we1  input  1  1 = write, 0 = read; held with req.
REQ-008 addr0, addr1  input  n  word address; held with req.
REQ-009 wdata0, wdata1  input  n  write data; held with req.
REQ-010 gnt0, gnt1  output  1  one-cycle pulse; request accepted and memory being accessed.
REQ-011 ack0, ack1  output  1  one-cycle pulse; transaction complete.
REQ-012 err0, err1  output  1  valid with ack; address out of range.
REQ-013 rdata0, rdata1  output  n  read data; valid with ack for reads.
REQ-014 mem_we  output  1  dmem write_enable.
REQ-015 mem_addr  output  n  dmem addr.
REQ-016 mem_wdata  output  n  dmem writedata.
REQ-017 mem_rdata  input  n  dmem readdata (combinational read).

Function
REQ-018 FSM states: IDLE, ACCESS, DONE, held in a registered state variable.
REQ-019 IDLE: if neither req is high, stay in IDLE.
REQ-020 IDLE: if any req is high, latch owner, we, addr, wdata and range flag from the winning port; next state ACCESS.
REQ-021 Arbitration: single request wins; on simultaneous req0 and req1, the port not served last wins (round-robin).
REQ-022 Round-robin pointer last_owner updates on every grant.
REQ-023 ACCESS: gnt<owner>=1 for exactly this cycle.
REQ-024 ACCESS: mem_addr = latched addr; mem_wdata = latched wdata; mem_we = latched we AND in-range.
REQ-025 ACCESS: for reads, capture mem_rdata into the owner's rdata register at the ACCESS->DONE edge; next state DONE.
REQ-026 Out-of-range transaction: mem_we stays 0; err<owner>=1 in DONE; rdata<owner>=0.
REQ-027 DONE: ack<owner>=1 for this cycle only; next state IDLE.
REQ-028 Latency: req sampled in IDLE at edge T; gnt in cycle T+1; ack in cycle T+2; minimum 3 cycles per transaction.
REQ-029 Outside ACCESS: mem_we=0 and mem_addr/mem_wdata=0.
REQ-030 Only one port is ever granted or acked at a time.
REQ-031 req is sampled only in IDLE; a requester keeps req and its fields stable until gnt and drops req the cycle after gnt unless issuing a new transaction.
REQ-032 rdata<x> holds its value until the next read completes for that port.
REQ-033 Write-to-read ordering: a read following a write to the same address, from either port, returns the written data.

Reset
REQ-034 While rst=1, asynchronously: state=IDLE; last_owner=1 so port 0 wins first contention; all gnt/ack/err=0; rdata0=rdata1=0; mem_we=0; mem_addr=mem_wdata=0.
REQ-035 Reset asserted during ACCESS forces mem_we=0 immediately, so no write occurs and the transaction is discarded with no ack.
REQ-036 After rst deasserts, the first rising edge evaluates IDLE normally.

Verification
REQ-037 Port 0 write addr=0x00 data=0xFFFFFFFF, then read addr=0x00 -> gnt0 one cycle after sample, ack0 one cycle later, rdata0=0xFFFFFFFF, err0=0.
REQ-038 req0 and req1 simultaneous after reset (reads addr 0x01, 0x02) -> port 0 served first, then port 1; gnt pulses 3 cycles apart; never both high.
REQ-039 Both ports request continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-040 Port 1 write addr=0x80 (bit 7 set, r=7) data=0x1234 -> mem_we never high; ack1=1 with err1=1; subsequent read of addr 0x00 is unchanged.
REQ-041 Port 1 write 0x0000FFFF to addr 0x01, then port 0 read of 0x01 -> rdata0=0x0000FFFF.
REQ-042 rst pulsed mid-ACCESS of a write of 0xDEADBEEF to addr 0x02 -> mem_we drops the same cycle, no ack, and a later read of 0x02 returns its prior value.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Bundle of every signal around the two-port data-memory arbiter.
//   Port 0 (CPU) and port 1 (aux/debug):
//     req, we, addr, wdata   requester -> arbiter, held stable until gnt
//     gnt, ack, err, rdata   arbiter -> requester, gnt/ack are 1-cycle pulses
//   Memory side:
//     mem_we, mem_addr, mem_wdata   arbiter -> dmem
//     mem_rdata                     dmem -> arbiter (combinational read)
// Modports: master = requesters, slave = arbiter, mem = data memory.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int n = 32
) ();
    logic         req0,   req1;
    logic         we0,    we1;
    logic [n-1:0] addr0,  addr1;
    logic [n-1:0] wdata0, wdata1;
    logic         gnt0,   gnt1;
    logic         ack0,   ack1;
    logic         err0,   err1;
    logic [n-1:0] rdata0, rdata1;

    logic         mem_we;
    logic [n-1:0] mem_addr;
    logic [n-1:0] mem_wdata;
    logic [n-1:0] mem_rdata;

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1
    );

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, ack0, ack1, err0, err1, rdata0, rdata1,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport mem (
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-ported data memory between two requesters (port 0 = CPU,
// port 1 = aux/debug). Each transaction takes IDLE -> ACCESS -> DONE:
//   IDLE   : sample req0/req1, latch the winner's command
//   ACCESS : gnt pulse to the owner, memory driven (write happens here)
//   DONE   : ack pulse to the owner, err flags an out-of-range address
// Contention is resolved round-robin against the last granted port.
// Ports:
//   clk  rising-edge clock shared with dmem
//   rst  asynchronous active-high reset
//   bus  dmem_arbiter_if.slave (requester handshakes + dmem bus)
// Parameters:
//   n  data/address width
//   r  implemented address bits; addr[n-1:r] must be zero
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int n = 32,
    parameter int r = 7
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    localparam int NUM_PORTS = 2;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t state, state_nxt;

    // Packed per-port views of the scalar interface signals.
    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we_in;
    logic [NUM_PORTS-1:0][n-1:0] addr_in;
    logic [NUM_PORTS-1:0][n-1:0] wdata_in;
    logic [NUM_PORTS-1:0]        gnt;
    logic [NUM_PORTS-1:0]        ack;
    logic [NUM_PORTS-1:0]        err;
    logic [NUM_PORTS-1:0][n-1:0] rdata_q;

    assign req      = {bus.req1,   bus.req0};
    assign we_in    = {bus.we1,    bus.we0};
    assign addr_in  = {bus.addr1,  bus.addr0};
    assign wdata_in = {bus.wdata1, bus.wdata0};

    assign bus.gnt0   = gnt[0];
    assign bus.gnt1   = gnt[1];
    assign bus.ack0   = ack[0];
    assign bus.ack1   = ack[1];
    assign bus.err0   = err[0];
    assign bus.err1   = err[1];
    assign bus.rdata0 = rdata_q[0];
    assign bus.rdata1 = rdata_q[1];

    // Latched transaction.
    logic         owner;
    logic         last_owner;
    logic         we_l;
    logic [n-1:0] addr_l;
    logic [n-1:0] wdata_l;
    logic         oor_l;      // latched address was out of range

    // Arbitration: a lone request wins; on contention the port that was not
    // served last wins.
    logic         winner;
    logic [n-1:0] win_addr;
    logic         win_oor;
    logic         load;

    always_comb begin
        if (req == 2'b11)
            winner = ~last_owner;
        else
            winner = req[1];
    end

    assign win_addr = addr_in[winner];
    // Upper bits beyond the implemented range must be zero.
    assign win_oor  = (win_addr >> r) != '0;

    // Next state and outputs. Everything decodes from the registered state,
    // so an asynchronous reset drops gnt/ack/err/mem_we in the same cycle.
    always_comb begin
        state_nxt     = state;
        load          = 1'b0;
        gnt           = '0;
        ack           = '0;
        err           = '0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    load      = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                gnt[owner]    = 1'b1;
                bus.mem_we    = we_l & ~oor_l;
                bus.mem_addr  = addr_l;
                bus.mem_wdata = wdata_l;
                state_nxt     = DONE;
            end
            DONE: begin
                ack[owner] = 1'b1;
                err[owner] = oor_l;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;   // port 0 wins the first contention
            we_l       <= 1'b0;
            addr_l     <= '0;
            wdata_l    <= '0;
            oor_l      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                owner      <= winner;
                last_owner <= winner;
                we_l       <= we_in[winner];
                addr_l     <= win_addr;
                wdata_l    <= wdata_in[winner];
                oor_l      <= win_oor;
            end
        end
    end

    // Per-port read-data registers. Captured at the ACCESS->DONE edge for
    // reads; any out-of-range transaction returns zero instead of memory
    // data. Otherwise the register holds until that port's next read.
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rdata
        logic cap;
        assign cap = (state == ACCESS) && (owner == 1'(p)) && (!we_l || oor_l);

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                rdata_q[p] <= '0;
            else if (cap)
                rdata_q[p] <= oor_l ? '0 : bus.mem_rdata;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int N = 32;
    localparam int R = 7;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_arbiter_if #(.n(N)) bus ();

    dmem_arbiter #(.n(N), .r(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Behavioural dmem: combinational read, write on rising edge.
    logic [N-1:0] mem [0:(1<<R)-1];
    always @(posedge clk) if (bus.mem_we) mem[bus.mem_addr[R-1:0]] <= bus.mem_wdata;
    assign bus.mem_rdata = mem[bus.mem_addr[R-1:0]];

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        bit           port;
        bit           we;
        logic [N-1:0] addr;
        logic [N-1:0] wdata;
        bit           exp_err;
        bit           chk_rd;
        logic [N-1:0] exp_rd;
    } vec_t;

    vec_t vecs [12];

    function automatic logic get_gnt(input bit p);  return p ? bus.gnt1 : bus.gnt0; endfunction
    function automatic logic get_ack(input bit p);  return p ? bus.ack1 : bus.ack0; endfunction
    function automatic logic get_err(input bit p);  return p ? bus.err1 : bus.err0; endfunction
    function automatic logic [N-1:0] get_rd(input bit p); return p ? bus.rdata1 : bus.rdata0; endfunction

    task automatic set_port(input bit p, input bit rq, input bit we, input logic [N-1:0] a, input logic [N-1:0] d);
        if (p) begin
            bus.req1 = rq; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = rq; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
        end
    endtask

    // Runs one transaction; entered and left on a falling edge in IDLE.
    task automatic txn(input vec_t v, input int idx);
        int cyc;
        bit got;
        cyc = 0;
        got = 1'b0;
        set_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        while (!got && cyc < 8) begin
            @(negedge clk);
            cyc++;
            if (get_gnt(v.port)) got = 1'b1;
        end
        chk($sformatf("v%0d gnt latency", idx), N'(cyc), N'(1));
        chk($sformatf("v%0d other gnt", idx), N'(get_gnt(~v.port)), N'(0));
        chk($sformatf("v%0d mem_we", idx), N'(bus.mem_we), N'(v.we && !v.exp_err));
        chk($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.addr);
        set_port(v.port, 1'b0, v.we, v.addr, v.wdata);
        @(negedge clk);
        chk($sformatf("v%0d ack", idx), N'(get_ack(v.port)), N'(1));
        chk($sformatf("v%0d other ack", idx), N'(get_ack(~v.port)), N'(0));
        chk($sformatf("v%0d err", idx), N'(get_err(v.port)), N'(v.exp_err));
        chk($sformatf("v%0d mem_we in DONE", idx), N'(bus.mem_we), N'(0));
        if (v.chk_rd) chk($sformatf("v%0d rdata", idx), get_rd(v.port), v.exp_rd);
        @(negedge clk);
        chk($sformatf("v%0d ack pulse end", idx), N'(get_ack(v.port)), N'(0));
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " flags"}, N'({bus.gnt0, bus.gnt1, bus.ack0, bus.ack1, bus.err0, bus.err1, bus.mem_we}), N'(0));
        chk({tag, " rdata0"}, bus.rdata0, '0);
        chk({tag, " rdata1"}, bus.rdata1, '0);
        chk({tag, " mem_addr"}, bus.mem_addr, '0);
        chk({tag, " mem_wdata"}, bus.mem_wdata, '0);
    endtask

    initial begin
        int t0, t1, both, k;
        bit seen;
        bit alt [6];

        //          port we  addr        wdata         err chk exp_rd
        vecs[0]  = '{0, 1, 32'h00,  32'hFFFF_FFFF, 0, 0, 32'h0};
        vecs[1]  = '{0, 0, 32'h00,  32'h0,         0, 1, 32'hFFFF_FFFF};
        vecs[2]  = '{1, 1, 32'h80,  32'h1234,      1, 0, 32'h0};
        vecs[3]  = '{0, 0, 32'h00,  32'h0,         0, 1, 32'hFFFF_FFFF};
        vecs[4]  = '{1, 1, 32'h01,  32'h0000_FFFF, 0, 0, 32'h0};
        vecs[5]  = '{0, 0, 32'h01,  32'h0,         0, 1, 32'h0000_FFFF};
        vecs[6]  = '{1, 0, 32'h01,  32'h0,         0, 1, 32'h0000_FFFF};
        vecs[7]  = '{0, 1, 32'h7F,  32'hA5A5_A5A5, 0, 0, 32'h0};
        vecs[8]  = '{1, 0, 32'h7F,  32'h0,         0, 1, 32'hA5A5_A5A5};
        vecs[9]  = '{0, 0, 32'h100, 32'h0,         1, 1, 32'h0};
        vecs[10] = '{0, 1, 32'h02,  32'h1111_1111, 0, 0, 32'h0};
        vecs[11] = '{1, 0, 32'h02,  32'h0,         0, 1, 32'h1111_1111};

        alt = '{0, 1, 0, 1, 0, 1};

        for (int i = 0; i < (1 << R); i++) mem[i] = '0;
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);

        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk_reset_state("reset");
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) txn(vecs[i], i);

        // Reset again so last_owner is back at 1, then contend.
        rst = 1'b1;
        @(negedge clk);
        chk_reset_state("reset2");
        rst = 1'b0;
        @(negedge clk);

        t0 = 0; t1 = 0; both = 0;
        set_port(0, 1, 0, 32'h01, '0);
        set_port(1, 1, 0, 32'h02, '0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (bus.gnt0 && bus.gnt1) both++;
            if (bus.gnt0 && t0 == 0) begin t0 = c; bus.req0 = 1'b0; end
            if (bus.gnt1 && t1 == 0) begin t1 = c; bus.req1 = 1'b0; end
        end
        chk("contend gnt0 cycle", N'(t0), N'(1));
        chk("contend gnt1 cycle", N'(t1), N'(4));
        chk("contend both gnt", N'(both), N'(0));
        chk("contend rdata0", bus.rdata0, 32'h0000_FFFF);
        chk("contend rdata1", bus.rdata1, 32'h1111_1111);

        // Continuous requests from both ports: grants must alternate.
        k = 0; both = 0;
        set_port(0, 1, 0, 32'h00, '0);
        set_port(1, 1, 0, 32'h01, '0);
        for (int c = 0; c < 40 && k < 6; c++) begin
            @(negedge clk);
            if (bus.gnt0 && bus.gnt1) both++;
            if (bus.gnt0) begin chk($sformatf("rr grant %0d", k), N'(0), N'(alt[k])); k++; end
            else if (bus.gnt1) begin chk($sformatf("rr grant %0d", k), N'(1), N'(alt[k])); k++; end
            if (k == 6) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        chk("rr grant count", N'(k), N'(6));
        chk("rr both gnt", N'(both), N'(0));
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);

        // Reset in the middle of a write's ACCESS cycle.
        set_port(0, 1, 1, 32'h02, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("abort gnt0", N'(bus.gnt0), N'(1));
        chk("abort mem_we before rst", N'(bus.mem_we), N'(1));
        rst = 1'b1;
        #1;
        chk("abort mem_we after rst", N'(bus.mem_we), N'(0));
        chk("abort gnt0 after rst", N'(bus.gnt0), N'(0));
        chk("abort mem_addr after rst", bus.mem_addr, '0);
        @(negedge clk);
        rst = 1'b0;
        bus.req0 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1 || bus.gnt0 || bus.gnt1) seen = 1'b1;
        end
        chk("abort no ack", N'(seen), N'(0));
        txn('{1, 0, 32'h02, 32'h0, 0, 1, 32'h1111_1111}, 100);
        txn('{0, 0, 32'h02, 32'h0, 0, 1, 32'h1111_1111}, 101);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
